// File: rtl/irq_gateway_arb_pkg.sv
// irq_gw_pkg: shared types and sizing helpers for the interrupt gateway/arbiter.
package irq_gw_pkg;

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PENDING = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_e;

    localparam int NSRC_DEF = 8;

    function automatic int id_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/irq_gateway_arb_if.sv
// irq_gateway_arb_if: source, claim/complete and irq signals between hart side and gateway.
interface irq_gateway_arb_if
    import irq_gw_pkg::*;
#(
    parameter int NSrc = NSRC_DEF,
    parameter int IdW  = id_width(NSrc)
);
    logic [NSrc-1:0] intr_src_i;
    logic [NSrc-1:0] src_en_i;
    logic            irq_o;
    logic [IdW-1:0]  irq_id_o;
    logic            claim_i;
    logic [IdW-1:0]  claim_id_o;
    logic            complete_i;
    logic [IdW-1:0]  complete_id_i;

    modport master (
        output intr_src_i, src_en_i, claim_i, complete_i, complete_id_i,
        input  irq_o, irq_id_o, claim_id_o
    );

    modport slave (
        input  intr_src_i, src_en_i, claim_i, complete_i, complete_id_i,
        output irq_o, irq_id_o, claim_id_o
    );
endinterface

// File: rtl/irq_gateway_arb_src.sv
// irq_gw_src: per-source IDLE/PENDING/CLAIMED gateway FSM.
// IRQ_GW_SYNC_EN adds a 2-flop input synchronizer ahead of the FSM.
module irq_gw_src
    import irq_gw_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    input  logic claim_hit_i,
    input  logic complete_hit_i,
    output logic pending_o
);
    logic      level;
    gw_state_e state_q, state_d;

`ifdef IRQ_GW_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[0], level_i};
    end
    assign level = sync_q[1];
`else
    assign level = level_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= GW_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == GW_IDLE    && level)          ? GW_PENDING :
                  (state_q == GW_PENDING && claim_hit_i)    ? GW_CLAIMED :
                  (state_q == GW_CLAIMED && complete_hit_i) ? GW_IDLE    : state_q;
    end

    always_comb begin
        pending_o = (state_q == GW_PENDING);
    end
endmodule

// File: rtl/irq_gateway_arb.sv
// irq_gateway_arb: latches level interrupts, arbitrates lowest-index enabled pending source.
// Define IRQ_GW_SYNC_EN to synchronize intr_src_i (source-to-irq latency 4 instead of 2).
module irq_gateway_arb
    import irq_gw_pkg::*;
#(
    parameter int NSrc = NSRC_DEF,
    parameter int IdW  = id_width(NSrc)
) (
    input logic              clk_i,
    input logic              rst_i,
    irq_gateway_arb_if.slave bus
);
    logic [NSrc-1:0] pend, claim_hit, complete_hit, req;
    logic            irq_q, irq_d;
    logic [IdW-1:0]  irq_id_q, irq_id_d, claim_id_q, claim_id_d;

    for (genvar i = 0; i < NSrc; i++) begin : g_src
        assign claim_hit[i]    = bus.claim_i && irq_q && (irq_id_q == IdW'(i + 1));
        assign complete_hit[i] = bus.complete_i && (bus.complete_id_i == IdW'(i + 1));
        irq_gw_src u_src (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .level_i        (bus.intr_src_i[i]),
            .claim_hit_i    (claim_hit[i]),
            .complete_hit_i (complete_hit[i]),
            .pending_o      (pend[i])
        );
    end

    // Drop the source being claimed now so back-to-back claims see the next winner.
    assign req = pend & bus.src_en_i & ~claim_hit;

    always_comb begin
        irq_id_d = '0;
        for (int k = NSrc - 1; k >= 0; k--)
            if (req[k]) irq_id_d = IdW'(k + 1);
        irq_d      = |req;
        claim_id_d = bus.claim_i ? irq_id_q : claim_id_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q      <= 1'b0;
            irq_id_q   <= '0;
            claim_id_q <= '0;
        end else begin
            irq_q      <= irq_d;
            irq_id_q   <= irq_id_d;
            claim_id_q <= claim_id_d;
        end
    end

    assign bus.irq_o      = irq_q;
    assign bus.irq_id_o   = irq_id_q;
    assign bus.claim_id_o = claim_id_q;
endmodule

// File: tb/tb_irq_gateway_arb.sv
// tb_irq_gateway_arb: scenario tasks with a claim-ID scoreboard for irq_gateway_arb.
module tb_irq_gateway_arb;
    import irq_gw_pkg::*;

    localparam int NSrc = 8;
    localparam int IdW  = id_width(NSrc);
`ifdef IRQ_GW_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [IdW-1:0] exp_q[$];
    logic [IdW-1:0] e;

    irq_gateway_arb_if #(.NSrc(NSrc), .IdW(IdW)) bus ();
    irq_gateway_arb #(.NSrc(NSrc), .IdW(IdW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tickn(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.intr_src_i = '0;
        bus.claim_i = 1'b0;
        bus.complete_i = 1'b0;
        bus.complete_id_i = '0;
        tickn(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.src_en_i = 8'hFF;
        bus.intr_src_i = 8'h01;
        tickn(3);
        checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", bus.irq_o); end
        checks++; if (bus.irq_id_o !== '0) begin errors++; $display("FAIL reset_id: got %0d want 0", bus.irq_id_o); end
        checks++; if (bus.claim_id_o !== '0) begin errors++; $display("FAIL reset_claim_id: got %0d want 0", bus.claim_id_o); end
        rst = 1'b0;
        tickn(LAT - 1);
        checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL reset_early_irq: got %b want 0", bus.irq_o); end
        tickn(1);
        checks++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== IdW'(1)) begin errors++; $display("FAIL reset_release: got irq=%b id=%0d want irq=1 id=1", bus.irq_o, bus.irq_id_o); end
    endtask

    task automatic test_priority();
        do_reset();
        bus.src_en_i = 8'hFF;
        bus.intr_src_i = 8'h0C;
        tickn(LAT);
        checks++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== IdW'(3)) begin errors++; $display("FAIL prio_first: got irq=%b id=%0d want irq=1 id=3", bus.irq_o, bus.irq_id_o); end
        bus.claim_i = 1'b1;
        exp_q.push_back(IdW'(3));
        tickn(1);
        e = exp_q.pop_front();
        checks++; if (bus.claim_id_o !== e) begin errors++; $display("FAIL prio_claim1: got %0d want %0d", bus.claim_id_o, e); end
        checks++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== IdW'(4)) begin errors++; $display("FAIL prio_next: got irq=%b id=%0d want irq=1 id=4", bus.irq_o, bus.irq_id_o); end
        exp_q.push_back(IdW'(4));
        tickn(1);
        bus.claim_i = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus.claim_id_o !== e) begin errors++; $display("FAIL prio_claim2: got %0d want %0d", bus.claim_id_o, e); end
        checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL prio_drained: got %b want 0", bus.irq_o); end
    endtask

    task automatic test_complete();
        do_reset();
        bus.src_en_i = 8'hFF;
        bus.intr_src_i = 8'h01;
        tickn(LAT);
        checks++; if (bus.irq_id_o !== IdW'(1)) begin errors++; $display("FAIL cmp_first: got %0d want 1", bus.irq_id_o); end
        bus.claim_i = 1'b1;
        exp_q.push_back(IdW'(1));
        tickn(1);
        bus.claim_i = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus.claim_id_o !== e) begin errors++; $display("FAIL cmp_claim: got %0d want %0d", bus.claim_id_o, e); end
        bus.complete_i = 1'b1;
        bus.complete_id_i = IdW'(2);
        tickn(1);
        bus.complete_i = 1'b0;
        tickn(2);
        checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL cmp_wrong_id: got %b want 0", bus.irq_o); end
        bus.complete_i = 1'b1;
        bus.complete_id_i = IdW'(1);
        tickn(1);
        bus.complete_i = 1'b0;
        checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL cmp_edge1: got %b want 0", bus.irq_o); end
        tickn(1);
        checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL cmp_edge2: got %b want 0", bus.irq_o); end
        tickn(1);
        checks++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== IdW'(1)) begin errors++; $display("FAIL cmp_refire: got irq=%b id=%0d want irq=1 id=1", bus.irq_o, bus.irq_id_o); end
    endtask

    task automatic test_disabled();
        do_reset();
        bus.src_en_i = 8'h00;
        bus.intr_src_i = 8'h20;
        tickn(1);
        bus.intr_src_i = 8'h00;
        tickn(LAT + 1);
        checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL dis_hidden: got %b want 0", bus.irq_o); end
        bus.src_en_i = 8'h20;
        tickn(1);
        checks++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== IdW'(6)) begin errors++; $display("FAIL dis_enable: got irq=%b id=%0d want irq=1 id=6", bus.irq_o, bus.irq_id_o); end
    endtask

    task automatic test_claim_idle();
        bus.claim_i = 1'b1;
        exp_q.push_back(IdW'(6));
        tickn(1);
        bus.claim_i = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus.claim_id_o !== e) begin errors++; $display("FAIL idle_claim6: got %0d want %0d", bus.claim_id_o, e); end
        bus.claim_i = 1'b1;
        exp_q.push_back(IdW'(0));
        tickn(1);
        bus.claim_i = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus.claim_id_o !== e) begin errors++; $display("FAIL idle_claim0: got %0d want %0d", bus.claim_id_o, e); end
        bus.intr_src_i = 8'h20;
        tickn(LAT + 1);
        checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL idle_claimed_ignores: got %b want 0", bus.irq_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.src_en_i = 8'hFF;
        bus.intr_src_i = 8'h04;
        tickn(LAT);
        bus.claim_i = 1'b1;
        exp_q.push_back(IdW'(3));
        tickn(1);
        bus.claim_i = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus.claim_id_o !== e) begin errors++; $display("FAIL mid_claim: got %0d want %0d", bus.claim_id_o, e); end
        rst = 1'b1;
        tickn(1);
        checks++; if (bus.claim_id_o !== '0 || bus.irq_o !== 1'b0) begin errors++; $display("FAIL mid_reset: got irq=%b claim_id=%0d want 0 0", bus.irq_o, bus.claim_id_o); end
        rst = 1'b0;
        tickn(LAT - 1);
        checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL mid_early: got %b want 0", bus.irq_o); end
        tickn(1);
        checks++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== IdW'(3)) begin errors++; $display("FAIL mid_repend: got irq=%b id=%0d want irq=1 id=3", bus.irq_o, bus.irq_id_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.src_en_i = 8'hFF;
        bus.intr_src_i = 8'h03;
        tickn(LAT);
        bus.claim_i = 1'b1;
        exp_q.push_back(IdW'(1));
        tickn(1);
        e = exp_q.pop_front();
        checks++; if (bus.claim_id_o !== e || bus.irq_id_o !== IdW'(2)) begin errors++; $display("FAIL b2b_claim1: got claim_id=%0d id=%0d want %0d 2", bus.claim_id_o, bus.irq_id_o, e); end
        exp_q.push_back(IdW'(2));
        bus.complete_i = 1'b1;
        bus.complete_id_i = IdW'(1);
        tickn(1);
        bus.claim_i = 1'b0;
        bus.complete_i = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus.claim_id_o !== e || bus.irq_o !== 1'b0) begin errors++; $display("FAIL b2b_claim_cmp: got claim_id=%0d irq=%b want %0d 0", bus.claim_id_o, bus.irq_o, e); end
        tickn(2);
        checks++; if (bus.irq_o !== 1'b1 || bus.irq_id_o !== IdW'(1)) begin errors++; $display("FAIL b2b_refire: got irq=%b id=%0d want irq=1 id=1", bus.irq_o, bus.irq_id_o); end
        bus.claim_i = 1'b1;
        bus.complete_i = 1'b1;
        bus.complete_id_i = IdW'(1);
        exp_q.push_back(IdW'(1));
        tickn(1);
        bus.claim_i = 1'b0;
        bus.complete_i = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus.claim_id_o !== e) begin errors++; $display("FAIL b2b_same_claim: got %0d want %0d", bus.claim_id_o, e); end
        tickn(3);
        checks++; if (bus.irq_o !== 1'b0) begin errors++; $display("FAIL b2b_same_cmp_ignored: got %b want 0", bus.irq_o); end
    endtask

    initial begin
        bus.intr_src_i = '0;
        bus.src_en_i = '0;
        bus.claim_i = 1'b0;
        bus.complete_i = 1'b0;
        bus.complete_id_i = '0;
        test_reset();
        test_priority();
        test_complete();
        test_disabled();
        test_claim_idle();
        test_reset_mid();
        test_back_to_back();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/irq_gateway_arb.md
Name: irq_gateway_arb

Overview:
- Interrupt gateway and arbiter sitting directly downstream of the machine timer and the other peripheral interrupt outputs.
- Latches level-sensitive interrupt sources into pending state and selects the highest-priority enabled pending source.
- Presents a single registered irq line plus source ID to the hart.
- Enforces a claim/complete handshake so a source cannot re-fire until software completes it.
- Source index 0 is the timer-expired interrupt (ID 1).

Parameters:
- NSrc, 8, number of interrupt sources (1..31).
- IdW, $clog2(NSrc+1), width of source ID; ID 0 means "none", source i has ID i+1.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- intr_src_i  input  NSrc  level interrupt requests; bit 0 = timer expired.
- src_en_i  input  NSrc  per-source enable (static config from CSR).
- irq_o  output  1  interrupt request to hart.
- irq_id_o  output  IdW  ID of the winning pending source; 0 when irq_o low.
- claim_i  input  1  single-cycle claim strobe from hart.
- claim_id_o  output  IdW  ID captured by the most recent claim; 0 if no claim was granted.
- complete_i  input  1  single-cycle completion strobe.
- complete_id_i  input  IdW  ID being completed.

Behaviour:
- Reset: all sources IDLE. irq_o=0, irq_id_o=0, claim_id_o=0. Reset mid-operation discards pending and claimed state; sources still high re-pend on the first cycle after reset deasserts.
- Per-source FSM with states IDLE, PENDING, CLAIMED:
  - IDLE -> PENDING when intr_src_i[i]=1, whether or not the source is enabled.
  - PENDING -> CLAIMED on a claim whose sampled irq_id_o equals i+1.
  - CLAIMED -> IDLE on complete_i with complete_id_i==i+1.
  - CLAIMED ignores intr_src_i.
  - A complete whose ID does not match a CLAIMED source is ignored, and no state changes.
- Arbitration: among sources that are PENDING and enabled, the lowest index wins (timer has highest priority). The result is registered into irq_o/irq_id_o.
- Latency:
  - intr_src_i rising at edge n -> PENDING after edge n -> irq_o=1 after edge n+1, giving 2 cycles.
  - complete -> IDLE after the edge; a still-high source is PENDING after the next edge and irq_o is asserted one edge later.
- Claim:
  - When claim_i=1 and irq_o=1, the winner (irq_id_o) moves to CLAIMED and claim_id_o<=irq_id_o.
  - irq_o/irq_id_o are recomputed the following cycle, so a second claim in back-to-back cycles receives the next winner.
  - claim_i while irq_o=0 sets claim_id_o<=0 and changes no state.
- Simultaneous events:
  - A claim of source A and a complete of source B in the same cycle are both applied.
  - A claim and a complete of the same ID in the same cycle: the claim acts on PENDING, so the complete is ignored.
  - A new source rising in the same cycle as a claim is not considered until the following arbitration.
- Disabled source: may sit PENDING indefinitely and is invisible to arbitration. Enabling it makes irq_o assert within 1 cycle.
- ID encoding: priority-encoded, width IdW, with no wrap. IDs above NSrc are treated as non-matching.

Optional Feature:
- IRQ_GW_SYNC_EN defined: each intr_src_i bit passes through a 2-flop synchronizer, reset to 0, before the gateway FSM. Source-to-irq_o latency becomes 4 cycles. Intended for sources in another clock domain.
- Undefined: inputs are used directly and latency is 2 cycles.

Decomposition:
- Package irq_gw_pkg holds:
  - the enum gw_state_e {GW_IDLE, GW_PENDING, GW_CLAIMED} (2-bit encoded);
  - the default NSrc;
  - the function id_width(n).
- Sub-module irq_gw_src, one per source via generate, contains:
  - the per-source FSM and optional synchronizer;
  - inputs: level, claim_hit, complete_hit;
  - output: pending.
- The top level holds the enable mask, the priority encoder, the output registers and claim_id_o.

Test Plan:
- Reset with intr_src_i=8'h01 held -> irq_o=0 during reset; after release irq_o=1, irq_id_o=1 on the 2nd edge.
- intr_src_i=8'h0C, src_en_i=8'hFF -> irq_id_o=3. Claim -> claim_id_o=3, next cycle irq_id_o=4. Claim -> claim_id_o=4, then irq_o=0.
- Source 0 claimed with level held high, complete_id_i=2 issued -> ignored, irq_o stays 0. complete_id_i=1 -> irq_o=1, irq_id_o=1 two cycles later.
- src_en_i=8'h00, intr_src_i=8'h20 pulsed 1 cycle -> irq_o=0. Set src_en_i=8'h20 -> irq_o=1, irq_id_o=6 the next cycle (pending retained).
- claim_i with irq_o=0 -> claim_id_o=0 and no state change. Assert rst_i while source 2 is CLAIMED -> after reset, source 2 is PENDING if its level is still high.
- With IRQ_GW_SYNC_EN defined: source 1 rising -> irq_o=1, irq_id_o=2 after exactly 4 edges.
